// File: rtl/bf_alu.sv
// bf_alu: 8-bit tape-cell update unit (keep / decrement / increment).
// Ports: clk, rst (async, active-high); a, nochange, decrement,
//   increment in; out, zero, wrap, sel_err combinational out;
//   out_q, zero_q, err_sticky registered out.
module bf_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             nochange,
  input  logic             decrement,
  input  logic             increment,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             wrap,
  output logic             sel_err,
  output logic [WIDTH-1:0] out_q,
  output logic             zero_q,
  output logic             err_sticky
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ALL1 = '1;

  logic [2:0]       sel;
  logic [WIDTH-1:0] a_dec;
  logic [WIDTH-1:0] a_inc;

  assign sel   = {increment, decrement, nochange};
  assign a_dec = a - ONE;
  assign a_inc = a + ONE;

  // Any pattern other than a single hot select passes a through
  // and flags an error; there is deliberately no priority.
  always_comb begin
    out     = a;
    wrap    = 1'b0;
    sel_err = 1'b0;
    case (sel)
      3'b001: out = a;
      3'b010: begin
        out  = a_dec;
        wrap = (a == ZERO);
      end
      3'b100: begin
        out  = a_inc;
        wrap = (a == ALL1);
      end
      default: sel_err = 1'b1;
    endcase
  end

  assign zero = (out == ZERO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= ZERO;
      zero_q     <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      out_q      <= out;
      zero_q     <= zero;
      err_sticky <= err_sticky | sel_err;
    end
  end

endmodule

// File: tb/tb_bf_alu.sv
// tb_bf_alu: self-checking bench for bf_alu.
// Directed cases plus randomized stimulus against an arithmetic model.
module tb_bf_alu;

  localparam int M = 256;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic       nochange;
  logic       decrement;
  logic       increment;
  logic [7:0] out;
  logic       zero;
  logic       wrap;
  logic       sel_err;
  logic [7:0] out_q;
  logic       zero_q;
  logic       err_sticky;

  int n_cmp = 0;
  int n_bad = 0;
  bit exp_sticky = 0;

  bf_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .a(a),
    .nochange(nochange), .decrement(decrement),
    .increment(increment), .out(out), .zero(zero),
    .wrap(wrap), .sel_err(sel_err), .out_q(out_q),
    .zero_q(zero_q), .err_sticky(err_sticky)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic void model(
    input int av, input bit n, input bit d, input bit i,
    output int o, output bit w, output bit e);
    int c;
    c = int'(n) + int'(d) + int'(i);
    o = av; w = 0; e = 0;
    if (c != 1) e = 1;
    else if (d) begin o = (av + M - 1) % M; w = (av == 0); end
    else if (i) begin o = (av + 1) % M; w = (av == M - 1); end
  endfunction

  task automatic drive(input int av, input bit n,
                       input bit d, input bit i);
    a = av[7:0]; nochange = n; decrement = d; increment = i;
  endtask

  task automatic test_reset;
    rst = 1;
    drive(8'h33, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_q, zero_q, err_sticky} !== 10'h0) begin
      n_bad++;
      $display("FAIL reset_state: got out_q=%h zero_q=%b err=%b want 0/0/0",
               out_q, zero_q, err_sticky);
    end
    n_cmp++;
    if (out !== 8'h33) begin
      n_bad++;
      $display("FAIL reset_comb: got out=%h want 33", out);
    end
    @(negedge clk);
    rst = 0;
    exp_sticky = 0;
  endtask

  task automatic test_directed;
    // a, n, d, i, out, zero, wrap, err
    int tv [8][8] = '{
      '{8'hAD, 1, 0, 0, 8'hAD, 0, 0, 0},
      '{8'hAD, 0, 1, 0, 8'hAC, 0, 0, 0},
      '{8'hAD, 0, 0, 1, 8'hAE, 0, 0, 0},
      '{8'hFF, 0, 0, 1, 8'h00, 1, 1, 0},
      '{8'h00, 0, 1, 0, 8'hFF, 0, 1, 0},
      '{8'h01, 0, 1, 0, 8'h00, 1, 0, 0},
      '{8'h00, 1, 0, 0, 8'h00, 1, 0, 0},
      '{8'hFE, 0, 0, 1, 8'hFF, 0, 0, 0}
    };
    for (int k = 0; k < 8; k++) begin
      drive(tv[k][0], tv[k][1] != 0, tv[k][2] != 0, tv[k][3] != 0);
      #1;
      n_cmp++;
      if (out !== tv[k][4][7:0] || zero !== (tv[k][5] != 0) ||
          wrap !== (tv[k][6] != 0) || sel_err !== (tv[k][7] != 0)) begin
        n_bad++;
        $display("FAIL directed[%0d]: got out=%h z=%b w=%b e=%b want %h %0d %0d %0d",
                 k, out, zero, wrap, sel_err, tv[k][4][7:0],
                 tv[k][5], tv[k][6], tv[k][7]);
      end
    end
  endtask

  task automatic test_registered;
    @(negedge clk);
    drive(8'h10, 0, 0, 1);
    @(posedge clk); #1;
    n_cmp++;
    if (out_q !== 8'h11 || zero_q !== 1'b0 || err_sticky !== 1'b0) begin
      n_bad++;
      $display("FAIL reg_inc: got out_q=%h zq=%b err=%b want 11 0 0",
               out_q, zero_q, err_sticky);
    end
    @(negedge clk);
    drive(8'h01, 0, 1, 0);
    @(posedge clk); #1;
    n_cmp++;
    if (out_q !== 8'h00 || zero_q !== 1'b1 || err_sticky !== 1'b0) begin
      n_bad++;
      $display("FAIL reg_dec: got out_q=%h zq=%b err=%b want 00 1 0",
               out_q, zero_q, err_sticky);
    end
  endtask

  task automatic test_invalid;
    @(negedge clk);
    drive(8'h42, 0, 0, 0);
    #1;
    n_cmp++;
    if (out !== 8'h42 || sel_err !== 1'b1 || wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL none_sel: got out=%h e=%b w=%b want 42 1 0",
               out, sel_err, wrap);
    end
    n_cmp++;
    if (err_sticky !== 1'b0) begin
      n_bad++;
      $display("FAIL sticky_early: got %b want 0", err_sticky);
    end
    drive(8'h42, 0, 1, 1);
    #1;
    n_cmp++;
    if (out !== 8'h42 || sel_err !== 1'b1 || wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL two_sel: got out=%h e=%b w=%b want 42 1 0",
               out, sel_err, wrap);
    end
    drive(8'hFF, 1, 1, 1);
    #1;
    n_cmp++;
    if (out !== 8'hFF || sel_err !== 1'b1 || wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL three_sel: got out=%h e=%b w=%b want ff 1 0",
               out, sel_err, wrap);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (err_sticky !== 1'b1) begin
      n_bad++;
      $display("FAIL sticky_set: got %b want 1", err_sticky);
    end
    @(negedge clk);
    drive(8'h10, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (err_sticky !== 1'b1 || out_q !== 8'h11) begin
      n_bad++;
      $display("FAIL sticky_hold: got err=%b out_q=%h want 1 11",
               err_sticky, out_q);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    drive(8'h7F, 0, 0, 1);
    #2;
    rst = 1;
    #1;
    n_cmp++;
    if (out_q !== 8'h00 || zero_q !== 1'b0 || err_sticky !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: got out_q=%h zq=%b err=%b want 00 0 0",
               out_q, zero_q, err_sticky);
    end
    n_cmp++;
    if (out !== 8'h80 || sel_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_comb: got out=%h e=%b want 80 0",
               out, sel_err);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_q !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_hold: got out_q=%h want 00", out_q);
    end
    @(negedge clk);
    rst = 0;
    exp_sticky = 0;
  endtask

  task automatic test_random;
    int av, eo, pick;
    bit n, d, i, ew, ee;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      av = int'($urandom_range(0, 255));
      if (k % 5 == 0) av = (k % 10 == 0) ? 0 : 255;
      pick = int'($urandom_range(0, 15));
      n = 0; d = 0; i = 0;
      if (pick < 4) n = 1;
      else if (pick < 9) d = 1;
      else if (pick < 14) i = 1;
      else if (k > 150) begin
        n = $urandom_range(0, 1) != 0;
        d = $urandom_range(0, 1) != 0;
        i = 1;
      end else i = 1;
      drive(av, n, d, i);
      model(av, n, d, i, eo, ew, ee);
      #1;
      n_cmp++;
      if (out !== eo[7:0] || zero !== (eo == 0) ||
          wrap !== ew || sel_err !== ee) begin
        n_bad++;
        $display("FAIL rand_comb[%0d]: a=%h sel=%b%b%b got %h %b %b %b want %h %b %b %b",
                 k, av[7:0], i, d, n, out, zero, wrap, sel_err,
                 eo[7:0], eo == 0, ew, ee);
      end
      exp_sticky = exp_sticky | ee;
      @(posedge clk); #1;
      n_cmp++;
      if (out_q !== eo[7:0] || zero_q !== (eo == 0) ||
          err_sticky !== exp_sticky) begin
        n_bad++;
        $display("FAIL rand_reg[%0d]: got %h %b %b want %h %b %b",
                 k, out_q, zero_q, err_sticky, eo[7:0], eo == 0,
                 exp_sticky);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_registered;
    test_invalid;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
